common_dfffifo_1w1r: RTL
========================

# common_dfffifo_1w1r

Synchronous first-word-fall-through FIFO built on the DFF-based simple dual-port RAM. The push side drives the RAM's write-only port and the pop side drives its asynchronous read-only port. It is the standard small queue for decoupling pipeline stages in the core, such as fetch buffers and store/writeback queues. Depth is a power of two, and the block provides valid/ready handshakes on both ends.

## Interface
- FIFO_DATA_WIDTH, 8, width of each entry in bits
- FIFO_ADDR_WIDTH, 2, log2 of depth; depth = 2^FIFO_ADDR_WIDTH, minimum 1
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all entries
- push_valid  input  1  producer offers push_data this cycle
- push_ready  output  1  FIFO can accept an entry (not full)
- push_data  input  FIFO_DATA_WIDTH  entry to enqueue
- pop_valid  output  1  head entry available (not empty)
- pop_ready  input  1  consumer takes head entry this cycle
- pop_data  output  FIFO_DATA_WIDTH  head entry (combinational from storage)
- count  output  FIFO_ADDR_WIDTH+1  number of valid entries, 0..depth
- full  output  1  count == depth
- empty  output  1  count == 0

## Operation
- Storage: one RAM instance with the 2-address, write-enable, 1-read organisation. addra = wr_ptr low bits, ena = push_fire, wea = all ones, dina = push_data, addrb = rd_ptr low bits, doutb = pop_data.
- Storage contents are not reset. Only the pointers are state under reset.
- wr_ptr and rd_ptr are each FIFO_ADDR_WIDTH+1 bits wide. The MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (low bits equal) and (MSBs differ).
- count = wr_ptr − rd_ptr, modulo 2^(FIFO_ADDR_WIDTH+1).
- push_ready = !full. pop_valid = !empty. Both are derived only from registered pointers, with no combinational path from push_valid or pop_ready.
- push_fire = push_valid & push_ready & !flush. pop_fire = pop_valid & pop_ready & !flush.
- On push_fire, the word is written at wr_ptr and wr_ptr increments. On pop_fire, rd_ptr increments.
- Pointer increments wrap naturally. For example, with depth 4, pointer value 7 increments to 0.
- Simultaneous push_fire and pop_fire are allowed at any non-full, non-empty count. count is then unchanged and both pointers advance.
- When full, push_ready = 0, so only a pop can occur. The slot freed by that pop becomes writable on the next cycle; there is no same-cycle pass-through on full.
- When empty, pop_valid = 0 and there is no bypass. A pushed word appears at pop_data on the cycle after its push.
- While pop_valid = 0, pop_data is don't-care. Benches must not check it.
- flush = 1 at a rising edge sets rd_ptr to wr_ptr, making the FIFO empty on the next cycle.
  - Any push or pop in that cycle is ignored.
  - push_ready and pop_valid still reflect pre-flush state during the flush cycle.
- Producer rule: push_data must be held stable while push_valid=1 and push_ready=0. Dropping push_valid in that case is permitted; the FIFO does not enforce either.
- A push_valid asserted while full is not an error; it simply waits.

## Timing
- Reset values, asserted asynchronously while reset=0:
  - wr_ptr = rd_ptr = 0
  - count = 0, empty = 1, full = 0
  - push_ready = 1, pop_valid = 0
- Reset is asynchronous. Asserting it mid-transfer discards all entries immediately, without waiting for a clock edge.
- Release is sampled at the next rising edge. The first push may occur on the first edge after reset goes high.
- Push-to-pop latency: 1 cycle. A word pushed at edge N is visible on pop_data and pop_valid after edge N.
- pop_data updates combinationally with rd_ptr after each pop edge, giving back-to-back pops at 1 entry/cycle.
- Throughput: 1 push and 1 pop per cycle sustained.
- Outputs change only after clock edges or asynchronous reset, never from same-cycle inputs.

## Test plan
- Reset then fill: with depth 4 and width 8, push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count steps 1,2,3,4, full=1 and push_ready=0 after the 4th edge; a 5th push of 0x55 held for 3 cycles is not accepted.
- Drain in order: from full, pop_ready=1 for 4 cycles -> pop_data reads 0x11, 0x22, 0x33, 0x44 in order, then empty=1 and pop_valid=0, count=0.
- Wrap-around streaming: push and pop simultaneously for 20 cycles with an incrementing pattern starting at 0x00 while holding count=2 -> pops return the incrementing sequence with no loss or duplication through at least 2 pointer wraps, and count stays 2.
- Empty and full boundaries: at empty, push 0xA5 with pop_ready=1 -> no pop that cycle, pop_data=0xA5 with pop_valid=1 next cycle. At full, push_valid=1 and pop_ready=1 -> only the pop occurs, count goes 4→3, and the push is accepted the following cycle.
- Flush: with 3 entries, assert flush together with push_valid and pop_ready -> next cycle count=0 and empty=1, nothing was written. A subsequent push of 0x77 pops as 0x77.
- Async reset mid-operation: with 2 entries, drive reset=0 between clock edges -> count=0, empty=1, push_ready=1, pop_valid=0 before the next edge. After release, the first push/pop pair returns the new data.

Source files
------------

// File: rtl/common_dfffifo_1w1r.sv
// First-word-fall-through FIFO on a flop-based 1W/1R RAM.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.

module common_dffram_1w1r #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] wea,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; only the FIFO pointers qualify them.
  always_ff @(posedge clk) begin
    if (ena) mem[addra] <= (mem[addra] & ~wea) | (dina & wea);
  end

  assign doutb = mem[addrb];
endmodule

module common_dfffifo_1w1r #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [FIFO_DATA_WIDTH-1:0] pop_data,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = FIFO_ADDR_WIDTH;

  logic [AW:0] wr_ptr, rd_ptr;
  logic        push_fire, pop_fire;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count      = wr_ptr - rd_ptr;
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready && !flush;
  assign pop_fire   = pop_valid && pop_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  common_dffram_1w1r #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addra (wr_ptr[AW-1:0]),
    .ena   (push_fire),
    .wea   ({FIFO_DATA_WIDTH{1'b1}}),
    .dina  (push_data),
    .addrb (rd_ptr[AW-1:0]),
    .doutb (pop_data)
  );
endmodule
